djb2_arbiter: RTL and testbench
===============================

# djb2_arbiter

Shared djb2 hash engine with a round-robin front end. Up to NREQ requesters each stream a variable-length byte message; the block grants one requester at a time and folds its bytes into a 32-bit djb2 hash at one byte per cycle. It returns the hash, requester id and byte count through a valid/ready result port. The block sits between the byte-producing clients and the result consumer, replacing per-client fixed-length hash units.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester id, must satisfy 2**IDW >= NREQ
- SEED, 32'd5381, initial hash value

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset; clears all state
- req  input  NREQ  per-requester request, level
- in_data  input  8*NREQ  byte lanes; lane i is bits [8i+7:8i]
- in_valid  input  NREQ  per-lane byte valid
- in_last  input  NREQ  per-lane last-byte flag, qualified by in_valid
- in_ready  output  NREQ  per-lane byte accept
- gnt  output  NREQ  one-hot grant, registered
- out_hash  output  32  final hash
- out_id  output  IDW  index of the granted requester
- out_len  output  16  bytes hashed, saturating
- out_valid  output  1  result valid
- out_ready  input  1  result accept

## Operation
- States: IDLE, HASH, DONE.
- IDLE: if any req bit is high, pick the first set bit at or after rr_ptr (wrapping modulo NREQ). Register gnt one-hot, out_id = winner, hash = SEED, len = 0. Go to HASH.
- HASH: in_ready = gnt (only the winner's bit is high). On each edge with in_valid[w] & in_ready[w]: hash <= hash*33 + in_data lane w, computed as (hash<<5)+hash+byte, truncated mod 2^32. len <= len+1, saturating at 16'hFFFF; the hash keeps updating after saturation. If in_last[w] is high on that byte, go to DONE.
- DONE: out_valid = 1. out_hash, out_id and out_len are held stable while out_ready is low. On out_valid & out_ready: rr_ptr <= (winner+1) mod NREQ, gnt <= 0, go to IDLE.
- The grant is held until the last byte is accepted. A requester dropping req mid-message does not end the message. Lanes of non-granted requesters are ignored, and their in_ready stays 0.
- Messages have at least one byte. A granted requester that never sends a byte stalls the block; there is no timeout.
- Reset values: state IDLE, rr_ptr 0, gnt 0, in_ready 0, out_valid 0, out_hash SEED, out_id 0, out_len 0.

## Timing
- Request to grant latency: req is sampled at edge N, gnt is high after edge N. The first byte can be accepted at edge N+1.
- Throughput in HASH: one byte per cycle while in_valid is held high.
- The last byte is accepted at edge K, and out_valid is high after edge K. out_hash already includes that byte.
- The result handshake completes at edge M. After edge M the block is in IDLE with gnt=0 and out_valid=0. The next grant comes at the earliest after edge M+1, so there are 2 idle cycles between messages.
- in_ready is combinational from state and gnt only. It never depends on in_valid.
- Simultaneous requests are resolved by rr_ptr only. A new request arriving during HASH or DONE waits.
- rst_n asserted at any point clears state immediately, without waiting for a clock edge. Any partial message is discarded and no out_valid is produced for it.

## Test plan
- Reset: assert rst_n low mid-message -> gnt=0, in_ready=0, out_valid=0, out_hash=5381 immediately. After release with no requests, the block stays IDLE.
- Single message: requester 0 sends "abc" (0x61,0x62,0x63, last on 0x63) -> out_hash=32'd193485963, out_len=3, out_id=0, out_valid one cycle after the last byte.
- One-byte message: requester 2 sends 0x61 with last -> out_hash=32'd177670, out_len=1, out_id=2.
- Round-robin: req=4'b1111 held from reset, each requester sends 1 byte -> ids returned in order 0,1,2,3,0. Then with req=4'b1001 after id 0 completes -> next grant is id 3.
- Backpressure and stalls: in_valid toggles 1/0 during a 5-byte message -> hash equals the reference model. Then hold out_ready=0 for 5 cycles -> outputs stay stable, no new gnt, and the result is released on the first cycle out_ready=1.
- Wrap-around: 70000 bytes of 0xFF from requester 1 -> out_len=16'hFFFF, out_hash matches a mod-2^32 reference model, no gnt glitch.

Source files
------------

// File: rtl/djb2_arbiter.sv
// djb2_arbiter: shared djb2 hash engine behind a round-robin arbiter.
// NREQ requesters each stream a byte message. One requester holds the grant
// until its last byte has been hashed. The engine folds one byte per cycle
// into a 32-bit djb2 hash, then offers hash, id and length on a valid/ready port.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req[NREQ]            level request per requester
//   in_data[8*NREQ]      byte lanes, lane i at [8i+7:8i]
//   in_valid/in_last     per-lane byte valid and last-byte flag
//   in_ready[NREQ]       per-lane accept (only the granted lane, only in HASH)
//   gnt[NREQ]            registered one-hot grant
//   out_hash/id/len      result fields, held stable while out_valid & !out_ready
//   out_valid/out_ready  result handshake
module djb2_arbiter #(
  parameter int          NREQ = 4,
  parameter int          IDW  = 2,
  parameter logic [31:0] SEED = 32'd5381
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [8*NREQ-1:0]    in_data,
  input  logic [NREQ-1:0]      in_valid,
  input  logic [NREQ-1:0]      in_last,
  output logic [NREQ-1:0]      in_ready,
  output logic [NREQ-1:0]      gnt,
  output logic [31:0]          out_hash,
  output logic [IDW-1:0]       out_id,
  output logic [15:0]          out_len,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [1:0] {IDLE, HASH, DONE} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [31:0]     hash_q, hash_d;
  logic [15:0]     len_q, len_d;

  logic [NREQ-1:0][7:0] lanes;
  logic [7:0]           sel_byte;
  logic                 sel_valid, sel_last;

  assign lanes = in_data;

  // One-hot AND-OR lane mux keyed by the registered grant.
  always_comb begin
    sel_byte  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        sel_byte  = sel_byte | lanes[i];
        sel_valid = sel_valid | in_valid[i];
        sel_last  = sel_last | in_last[i];
      end
    end
  end

  // Round-robin pick: lowest set req at or above rr_ptr, otherwise the lowest
  // set req overall (the wrap). Scanning downward lets the last hit win.
  logic            hi_found, lo_found, pick_found;
  logic [IDW-1:0]  hi_id, lo_id, pick_id;
  logic [NREQ-1:0] hi_oh, lo_oh, pick_oh;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    hi_oh    = '0;
    lo_oh    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_id    = IDW'(i);
        lo_oh    = '0;
        lo_oh[i] = 1'b1;
        if (i >= int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
          hi_oh    = '0;
          hi_oh[i] = 1'b1;
        end
      end
    end
    pick_found = lo_found;
    pick_id    = hi_found ? hi_id : lo_id;
    pick_oh    = hi_found ? hi_oh : lo_oh;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    gnt_d    = gnt_q;
    hash_d   = hash_q;
    len_d    = len_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d   = pick_oh;
          id_d    = pick_id;
          hash_d  = SEED;
          len_d   = '0;
          state_d = HASH;
        end
      end
      HASH: begin
        // in_ready equals the grant here, so a valid on the granted lane is a transfer.
        if (sel_valid) begin
          hash_d = (hash_q << 5) + hash_q + {24'd0, sel_byte};
          len_d  = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
          if (sel_last) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
          gnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      gnt_q    <= '0;
      hash_q   <= SEED;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      gnt_q    <= gnt_d;
      hash_q   <= hash_d;
      len_q    <= len_d;
    end
  end

  assign in_ready  = (state_q == HASH) ? gnt_q : '0;
  assign gnt       = gnt_q;
  assign out_valid = (state_q == DONE);
  assign out_hash  = hash_q;
  assign out_id    = id_q;
  assign out_len   = len_q;

endmodule

// File: tb/tb_djb2_arbiter.sv
// Directed-sequence bench for djb2_arbiter with random payloads, checked
// against an arithmetic djb2 model and a search-based round-robin model.
module tb_djb2_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [8*NREQ-1:0]   in_data;
  logic [NREQ-1:0]     in_valid, in_last, in_ready, gnt;
  logic [31:0]         out_hash;
  logic [IDW-1:0]      out_id;
  logic [15:0]         out_len;
  logic                out_valid, out_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int ptr     = 0;
  bit gnt_glitch;
  logic [7:0] msg_q[$];

  always #5 clk = ~clk;

  djb2_arbiter #(.NREQ(NREQ), .IDW(IDW), .SEED(32'd5381)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .gnt(gnt), .out_hash(out_hash),
    .out_id(out_id), .out_len(out_len), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] djb2_step(input logic [31:0] h, input logic [7:0] b);
    return h * 33 + {24'd0, b};
  endfunction

  function automatic logic [31:0] djb2_msg();
    logic [31:0] h = 32'd5381;
    foreach (msg_q[i]) h = djb2_step(h, msg_q[i]);
    return h;
  endfunction

  // First requester with req set, searching from p upward modulo NREQ.
  function automatic int rr_pick(input int p, input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int id);
    logic [NREQ-1:0] v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Called at a negedge; returns at a negedge once a grant is visible.
  task automatic wait_gnt(input string tag, input int exp_id);
    int g = 0;
    while (gnt == '0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_gnt"}, gnt, onehot(exp_id));
    chk({tag, "_in_ready"}, in_ready, onehot(exp_id));
  endtask

  // Streams msg_q on lane id. Returns at the negedge after the last accepted byte.
  task automatic send_msg(input string tag, input int id, input bit toggle, input bit use_last);
    int i = 0;
    int guard = 0;
    int limit = 2 * msg_q.size() + 20;
    bit v, acc;
    gnt_glitch = 1'b0;
    while (i < msg_q.size() && guard < limit) begin
      v = toggle ? (guard % 2 == 0) : 1'b1;
      in_data = '0;
      in_data[8*id +: 8] = msg_q[i];
      in_valid = v ? onehot(id) : '0;
      in_last  = (use_last && i == msg_q.size() - 1) ? onehot(id) : '0;
      acc = v && in_ready[id];
      if (gnt !== onehot(id)) gnt_glitch = 1'b1;
      @(negedge clk);
      if (acc) i++;
      guard++;
    end
    in_valid = '0;
    in_last  = '0;
    if (i != msg_q.size()) chk({tag, "_send_timeout"}, i, msg_q.size());
  endtask

  task automatic chk_result(input string tag, input int id, input logic [31:0] h, input int len);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_hash"}, out_hash, h);
    chk({tag, "_id"}, out_id, id);
    chk({tag, "_len"}, out_len, (len > 65535) ? 65535 : len);
  endtask

  // One random-payload message from whoever the arbiter model predicts.
  task automatic rr_msg(input string tag, input logic [NREQ-1:0] r);
    int w;
    w = rr_pick(ptr, r);
    wait_gnt(tag, w);
    msg_q = {};
    msg_q.push_back(8'($urandom));
    send_msg(tag, w, 1'b0, 1'b1);
    chk_result(tag, w, djb2_msg(), 1);
    ptr = (w + 1) % NREQ;
    @(negedge clk); // handshake completes on the edge just passed
  endtask

  initial begin
    logic [31:0] sv_hash;
    int w;
    logic [31:0] h;

    rst_n = 1'b0; req = '0; in_data = '0; in_valid = '0; in_last = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, '0);
    chk("rst_in_ready", in_ready, '0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_hash", out_hash, 32'd5381);
    chk("rst_out_id", out_id, '0);
    chk("rst_out_len", out_len, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // "abc" from requester 0
    req = 4'b0001;
    wait_gnt("abc", rr_pick(ptr, req));
    msg_q = {8'h61, 8'h62, 8'h63};
    send_msg("abc", 0, 1'b0, 1'b1);
    chk_result("abc", 0, 32'd193485963, 3);
    ptr = 1;
    req = '0;
    @(negedge clk);
    chk("abc_released", out_valid, 1'b0);

    // single-byte message from requester 2
    req = 4'b0100;
    wait_gnt("one", rr_pick(ptr, req));
    msg_q = {8'h61};
    send_msg("one", 2, 1'b0, 1'b1);
    chk_result("one", 2, 32'd177670, 1);
    ptr = 3;
    req = '0;
    @(negedge clk);

    // asynchronous reset in the middle of a message from requester 1
    req = 4'b0010;
    wait_gnt("mid", rr_pick(ptr, req));
    msg_q = {8'h11, 8'h22};
    send_msg("mid", 1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt, '0);
    chk("mid_rst_in_ready", in_ready, '0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_hash", out_hash, 32'd5381);
    @(negedge clk);
    rst_n = 1'b1;
    req = '0;
    ptr = 0;
    repeat (5) @(negedge clk);
    chk("post_rst_gnt", gnt, '0);
    chk("post_rst_out_valid", out_valid, 1'b0);

    // round robin, all requesting
    req = 4'b1111;
    rr_msg("rr0", req);
    rr_msg("rr1", req);
    rr_msg("rr2", req);
    rr_msg("rr3", req);
    rr_msg("rr4", req);
    req = 4'b1001;
    chk("rr_model_next", rr_pick(ptr, req), 3);
    rr_msg("rr5", req);
    req = '0;

    // in_valid gaps, then result backpressure
    req = 4'b0001;
    w = rr_pick(ptr, req);
    wait_gnt("bp", w);
    msg_q = {};
    repeat (5) msg_q.push_back(8'($urandom));
    out_ready = 1'b0;
    send_msg("bp", w, 1'b1, 1'b1);
    sv_hash = djb2_msg();
    chk_result("bp", w, sv_hash, 5);
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_hash", out_hash, sv_hash);
      chk("bp_hold_len", out_len, 16'd5);
      chk("bp_hold_gnt", gnt, onehot(w));
    end
    out_ready = 1'b1;
    ptr = (w + 1) % NREQ;
    req = 4'b0010;
    @(negedge clk);
    chk("bp_released_valid", out_valid, 1'b0);
    chk("bp_released_gnt", gnt, '0);

    // 70000 x 0xFF from requester 1: length saturates, hash wraps mod 2^32
    w = rr_pick(ptr, req);
    wait_gnt("wrap", w);
    msg_q = {};
    h = 32'd5381;
    for (int i = 0; i < 70000; i++) begin
      msg_q.push_back(8'hFF);
      h = djb2_step(h, 8'hFF);
    end
    send_msg("wrap", w, 1'b0, 1'b1);
    chk("wrap_gnt_glitch", gnt_glitch, 1'b0);
    chk_result("wrap", w, h, 70000);
    req = '0;
    @(negedge clk);
    chk("wrap_released", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
